// File: rtl/stitch_wr_scheduler.sv
// Round-robin burst-command scheduler placing N camera rectangles into a ring of canvas frame buffers.
// Eligible in IDLE -> cmd_valid two cycles later; command held until cmd_ready; STITCH_FRAME_DROP_EN adds frame drop on early fstart.
module stitch_wr_scheduler #(
    parameter int          CH_NUM      = 3,
    parameter int          ADDR_W      = 32,
    parameter int          DATA_W      = 128,
    parameter int          BURST_LEN   = 16,
    parameter int          LVL_W       = 10,
    parameter logic [31:0] FB_BASE     = 32'h1000_0000,
    parameter logic [31:0] FRAME_BYTES = 32'h0080_0000,
    parameter int          LINE_STRIDE = 7680,
    parameter int          FB_NUM      = 3
) (
    input  logic                    M_AXI_ACLK,
    input  logic                    rst,
    input  logic [CH_NUM-1:0]       ch_enable,
    input  logic [CH_NUM-1:0]       ch_fstart,
    input  logic [CH_NUM*LVL_W-1:0] ch_level,
    input  logic [CH_NUM*12-1:0]    ch_x_word,
    input  logic [CH_NUM*12-1:0]    ch_y_line,
    input  logic [CH_NUM*12-1:0]    ch_w_word,
    input  logic [CH_NUM*12-1:0]    ch_h_line,
    output logic                    cmd_valid,
    input  logic                    cmd_ready,
    output logic [ADDR_W-1:0]       cmd_addr,
    output logic [7:0]              cmd_len,
    output logic [2:0]              cmd_ch,
    input  logic                    burst_done,
    output logic [CH_NUM-1:0]       frame_done,
`ifdef STITCH_FRAME_DROP_EN
    output logic [CH_NUM*16-1:0]    drop_cnt,
`endif
    output logic [CH_NUM*2-1:0]     wr_frame_idx
);
    localparam int BPW   = DATA_W / 8;
    localparam int SEL_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ARB, S_CMD, S_WAIT} state_t;

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    rr_q, rr_d, gnt_q, gnt_d, sel;
    logic [ADDR_W-1:0]   addr_q, addr_d, sel_addr;
    logic [7:0]          len_q, len_d;
    logic [8:0]          blen_q, blen_d, sel_blen;
    logic                any_elig, hi_found;
    logic [SEL_W-1:0]    lo_sel, hi_sel;

    logic [11:0]         x_q [CH_NUM];
    logic [11:0]         x_d [CH_NUM];
    logic [11:0]         y_q [CH_NUM];
    logic [11:0]         y_d [CH_NUM];
    logic [11:0]         nx  [CH_NUM];
    logic [11:0]         rem [CH_NUM];
    logic [1:0]          fidx_q [CH_NUM];
    logic [1:0]          fidx_d [CH_NUM];
    logic [8:0]          blen [CH_NUM];
    logic [ADDR_W-1:0]   ch_addr [CH_NUM];
    logic [CH_NUM-1:0]   armed_q, armed_d, fdone_q, fdone_d, elig;
`ifdef STITCH_FRAME_DROP_EN
    logic [15:0]         drop_q [CH_NUM];
    logic [15:0]         drop_d [CH_NUM];
`endif

    // Per-channel burst size, eligibility and start address of its next burst.
    always_comb begin
        for (int c = 0; c < CH_NUM; c++) begin
            rem[c]     = ch_w_word[c*12 +: 12] - x_q[c];
            blen[c]    = (rem[c] > 12'(BURST_LEN)) ? 9'(BURST_LEN) : rem[c][8:0];
            elig[c]    = ch_enable[c] && armed_q[c] &&
                         (32'(ch_level[c*LVL_W +: LVL_W]) >= 32'(blen[c]));
            ch_addr[c] = ADDR_W'(FB_BASE)
                       + ADDR_W'(fidx_q[c]) * ADDR_W'(FRAME_BYTES)
                       + (ADDR_W'(ch_y_line[c*12 +: 12]) + ADDR_W'(y_q[c])) * ADDR_W'(LINE_STRIDE)
                       + (ADDR_W'(ch_x_word[c*12 +: 12]) + ADDR_W'(x_q[c])) * ADDR_W'(BPW);
        end
    end

    // Round-robin: lowest eligible at or above rr pointer, else lowest eligible overall.
    always_comb begin
        any_elig = 1'b0;
        hi_found = 1'b0;
        lo_sel   = '0;
        hi_sel   = '0;
        for (int c = CH_NUM - 1; c >= 0; c--) begin
            if (elig[c]) begin
                any_elig = 1'b1;
                lo_sel   = SEL_W'(c);
                if (c >= int'(rr_q)) begin
                    hi_found = 1'b1;
                    hi_sel   = SEL_W'(c);
                end
            end
        end
        sel      = hi_found ? hi_sel : lo_sel;
        sel_addr = '0;
        sel_blen = '0;
        for (int c = 0; c < CH_NUM; c++) begin
            if (sel == SEL_W'(c)) begin
                sel_addr = ch_addr[c];
                sel_blen = blen[c];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        gnt_d   = gnt_q;
        addr_d  = addr_q;
        len_d   = len_q;
        blen_d  = blen_q;
        case (state_q)
            S_IDLE: if (any_elig) state_d = S_ARB;
            S_ARB: begin
                if (any_elig) begin
                    gnt_d   = sel;
                    addr_d  = sel_addr;
                    blen_d  = sel_blen;
                    len_d   = 8'(sel_blen - 9'd1);
                    state_d = S_CMD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CMD:  if (cmd_ready) state_d = S_WAIT;
            S_WAIT: begin
                if (burst_done) begin
                    state_d = S_IDLE;
                    rr_d    = (gnt_q == SEL_W'(CH_NUM - 1)) ? '0 : gnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Completion update first, then frame start, so a same-cycle fstart overrides it.
    always_comb begin
        for (int c = 0; c < CH_NUM; c++) begin
            x_d[c]     = x_q[c];
            y_d[c]     = y_q[c];
            fidx_d[c]  = fidx_q[c];
            armed_d[c] = armed_q[c];
            fdone_d[c] = 1'b0;
            nx[c]      = x_q[c] + 12'(blen_q);
`ifdef STITCH_FRAME_DROP_EN
            drop_d[c]  = drop_q[c];
`endif
            if (state_q == S_WAIT && burst_done && gnt_q == SEL_W'(c)) begin
                if (nx[c] >= ch_w_word[c*12 +: 12]) begin
                    x_d[c] = '0;
                    if (y_q[c] + 12'd1 >= ch_h_line[c*12 +: 12]) begin
                        y_d[c]     = '0;
                        armed_d[c] = 1'b0;
                        fdone_d[c] = 1'b1;
                        fidx_d[c]  = (fidx_q[c] == 2'(FB_NUM - 1)) ? 2'd0 : fidx_q[c] + 2'd1;
                    end else begin
                        y_d[c] = y_q[c] + 12'd1;
                    end
                end else begin
                    x_d[c] = nx[c];
                end
            end
            if (ch_enable[c] && ch_fstart[c]) begin
`ifdef STITCH_FRAME_DROP_EN
                if (armed_d[c] && drop_q[c] != 16'hFFFF) drop_d[c] = drop_q[c] + 16'd1;
                armed_d[c] = 1'b1;
                x_d[c]     = '0;
                y_d[c]     = '0;
`else
                if (!armed_d[c]) begin
                    armed_d[c] = 1'b1;
                    x_d[c]     = '0;
                    y_d[c]     = '0;
                end
`endif
            end
        end
    end

    always_ff @(posedge M_AXI_ACLK) begin
        if (rst) begin
            state_q <= S_IDLE;
            rr_q    <= '0;
            gnt_q   <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            blen_q  <= '0;
            armed_q <= '0;
            fdone_q <= '0;
            for (int c = 0; c < CH_NUM; c++) begin
                x_q[c]    <= '0;
                y_q[c]    <= '0;
                fidx_q[c] <= '0;
`ifdef STITCH_FRAME_DROP_EN
                drop_q[c] <= '0;
`endif
            end
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            gnt_q   <= gnt_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            blen_q  <= blen_d;
            armed_q <= armed_d;
            fdone_q <= fdone_d;
            for (int c = 0; c < CH_NUM; c++) begin
                x_q[c]    <= x_d[c];
                y_q[c]    <= y_d[c];
                fidx_q[c] <= fidx_d[c];
`ifdef STITCH_FRAME_DROP_EN
                drop_q[c] <= drop_d[c];
`endif
            end
        end
    end

    assign cmd_valid  = (state_q == S_CMD);
    assign cmd_addr   = addr_q;
    assign cmd_len    = len_q;
    assign cmd_ch     = 3'(gnt_q);
    assign frame_done = fdone_q;

    always_comb begin
        for (int c = 0; c < CH_NUM; c++) begin
            wr_frame_idx[c*2 +: 2] = fidx_q[c];
`ifdef STITCH_FRAME_DROP_EN
            drop_cnt[c*16 +: 16]   = drop_q[c];
`endif
        end
    end
endmodule
